// File: rtl/ldtu_ctrl_pkg.sv
// Shared definitions for the LiTE-DTU link sequencer: state encoding and
// default parameter values used by the RTL and its testbench.
package ldtu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_SYNCH = 2'd2,
        ST_RUN   = 2'd3
    } ctrl_state_t;

    localparam int DEF_FLUSH_CYCLES = 8;
    localparam int DEF_SYNCH_MIN    = 16;
    localparam int DEF_HS_TIMEOUT   = 64;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_TMR_W        = 8;

endpackage

// File: rtl/ldtu_link_monitor.sv
// Link health monitor: saturating lost-data counter, handshake watchdog
// arithmetic and the sticky timeout flag, both cleared by clr_cnt.
module ldtu_link_monitor
    import ldtu_ctrl_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TMR_W      = DEF_TMR_W,
    parameter int HS_TIMEOUT = DEF_HS_TIMEOUT
) (
    input  logic             CLK,
    input  logic             rst_b,
    input  logic             in_run,
    input  logic             wd_active,
    input  logic             handshake,
    input  logic             losing_data,
    input  logic             clr_cnt,
    input  logic [TMR_W-1:0] wd_timer,
    output logic [TMR_W-1:0] wd_timer_next,
    output logic [CNT_W-1:0] lost_cnt,
    output logic             link_err
);

    localparam logic [TMR_W-1:0] HS_LIMIT = TMR_W'(HS_TIMEOUT);
    localparam logic [TMR_W-1:0] HS_LAST  = TMR_W'(HS_TIMEOUT - 1);

    logic [CNT_W-1:0] lost_cnt_reg;
    logic             link_err_reg;
    logic             wd_timeout;
    logic             cnt_inc;

    always_comb begin
        wd_timer_next = wd_timer;
        if (handshake) begin
            wd_timer_next = '0;
        end else if (wd_timer < HS_LIMIT) begin
            wd_timer_next = wd_timer + 1'b1;
        end
    end

    // Flag fires on the step that reaches the limit; the saturated timer
    // does not keep re-arming it after a clear.
    assign wd_timeout = wd_active && !handshake && (wd_timer == HS_LAST);
    assign cnt_inc    = in_run && losing_data && !(&lost_cnt_reg);

    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            lost_cnt_reg <= '0;
            link_err_reg <= 1'b0;
        end else if (clr_cnt) begin
            lost_cnt_reg <= '0;
            link_err_reg <= 1'b0;
        end else begin
            if (cnt_inc) begin
                lost_cnt_reg <= lost_cnt_reg + 1'b1;
            end
            if (wd_timeout) begin
                link_err_reg <= 1'b1;
            end
        end
    end

    assign lost_cnt = lost_cnt_reg;
    assign link_err = link_err_reg;

endmodule

// File: rtl/ldtu_link_ctrl.sv
// LiTE-DTU output datapath sequencer: start-up flush, calibration/test hold,
// synch pattern requests, per-orbit flush and link health monitoring.
module ldtu_link_ctrl
    import ldtu_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
    parameter int SYNCH_MIN    = DEF_SYNCH_MIN,
    parameter int HS_TIMEOUT   = DEF_HS_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int TMR_W        = DEF_TMR_W
) (
    input  logic             CLK,
    input  logic             rst_b,
    input  logic             cal_busy,
    input  logic             test_enable,
    input  logic             synch_req,
    input  logic             orbit_flush_en,
    input  logic             Orbit,
    input  logic             handshake,
    input  logic             losing_data,
    input  logic             clr_cnt,
    output logic             flush,
    output logic             synch,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lost_cnt,
    output logic             link_err
);

    localparam logic [TMR_W-1:0] FLUSH_LOAD = TMR_W'(FLUSH_CYCLES - 1);
    localparam logic [TMR_W-1:0] SYNCH_TGT  = TMR_W'(SYNCH_MIN);

    ctrl_state_t      state_reg, state_next;
    logic [TMR_W-1:0] timer_reg, timer_next;
    logic [TMR_W-1:0] wd_timer_next;
    logic             flush_reg, synch_reg, ready_reg;
    logic             hold_req;
    logic             wd_active;

    assign hold_req = cal_busy | test_enable;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        wd_active  = 1'b0;
        if (hold_req) begin
            state_next = ST_HOLD;
            timer_next = '0;
        end else begin
            case (state_reg)
                ST_HOLD: begin
                    state_next = ST_FLUSH;
                    timer_next = FLUSH_LOAD;
                end
                ST_FLUSH: begin
                    if (timer_reg == '0) begin
                        state_next = synch_req ? ST_SYNCH : ST_RUN;
                        timer_next = '0;
                    end else begin
                        timer_next = timer_reg - 1'b1;
                    end
                end
                ST_SYNCH: begin
                    // Minimum synch length is enforced even if the request drops early.
                    if (!synch_req && (timer_reg == SYNCH_TGT)) begin
                        state_next = ST_FLUSH;
                        timer_next = FLUSH_LOAD;
                    end else if (handshake && (timer_reg < SYNCH_TGT)) begin
                        timer_next = timer_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (synch_req) begin
                        state_next = ST_SYNCH;
                        timer_next = '0;
                    end else if (Orbit && orbit_flush_en) begin
                        state_next = ST_FLUSH;
                        timer_next = FLUSH_LOAD;
                    end else begin
                        wd_active  = 1'b1;
                        timer_next = wd_timer_next;
                    end
                end
                default: begin
                    state_next = ST_FLUSH;
                    timer_next = FLUSH_LOAD;
                end
            endcase
        end
    end

    // Control outputs are registered from the next state so they line up
    // exactly with state_reg and never glitch.
    always_ff @(posedge CLK) begin
        if (!rst_b) begin
            state_reg <= ST_FLUSH;
            timer_reg <= FLUSH_LOAD;
            flush_reg <= 1'b0;
            synch_reg <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
            flush_reg <= (state_next == ST_SYNCH) || (state_next == ST_RUN);
            synch_reg <= (state_next == ST_SYNCH);
            ready_reg <= (state_next == ST_RUN);
        end
    end

    ldtu_link_monitor #(
        .CNT_W      (CNT_W),
        .TMR_W      (TMR_W),
        .HS_TIMEOUT (HS_TIMEOUT)
    ) u_monitor (
        .CLK           (CLK),
        .rst_b         (rst_b),
        .in_run        (state_reg == ST_RUN),
        .wd_active     (wd_active),
        .handshake     (handshake),
        .losing_data   (losing_data),
        .clr_cnt       (clr_cnt),
        .wd_timer      (timer_reg),
        .wd_timer_next (wd_timer_next),
        .lost_cnt      (lost_cnt),
        .link_err      (link_err)
    );

    assign flush = flush_reg;
    assign synch = synch_reg;
    assign ready = ready_reg;
    assign state = state_reg;

endmodule

// File: tb/tb_ldtu_link_ctrl.sv
// Testbench for ldtu_link_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a cycle-count reference model.
module tb_ldtu_link_ctrl;
    import ldtu_ctrl_pkg::*;

    localparam int FLUSH_CYCLES = DEF_FLUSH_CYCLES;
    localparam int SYNCH_MIN    = DEF_SYNCH_MIN;
    localparam int HS_TIMEOUT   = DEF_HS_TIMEOUT;
    localparam int CNT_MAX      = (1 << DEF_CNT_W) - 1;

    logic       CLK = 1'b0;
    logic       rst_b, cal_busy, test_enable, synch_req, orbit_flush_en;
    logic       Orbit, handshake, losing_data, clr_cnt;
    logic       flush, synch, ready, link_err;
    logic [1:0] state;
    logic [7:0] lost_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode plus one counter per activity.
    int m_mode;        // 0 HOLD, 1 FLUSH, 2 SYNCH, 3 RUN
    int flush_left;    // FLUSH cycles still to spend, including the current one
    int hs_seen;       // handshakes seen since entering SYNCH
    int idle_cnt;      // RUN cycles since last handshake / RUN entry
    int m_lost;
    bit m_err;

    always #5 CLK = ~CLK;

    ldtu_link_ctrl dut (
        .CLK            (CLK),
        .rst_b          (rst_b),
        .cal_busy       (cal_busy),
        .test_enable    (test_enable),
        .synch_req      (synch_req),
        .orbit_flush_en (orbit_flush_en),
        .Orbit          (Orbit),
        .handshake      (handshake),
        .losing_data    (losing_data),
        .clr_cnt        (clr_cnt),
        .flush          (flush),
        .synch          (synch),
        .ready          (ready),
        .state          (state),
        .lost_cnt       (lost_cnt),
        .link_err       (link_err)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic enter_flush();
        m_mode     = 1;
        flush_left = FLUSH_CYCLES;
    endtask

    // Applies the sequencing rules to the inputs about to be sampled.
    task automatic model_step();
        bit was_run;
        bit err_set;
        was_run = (m_mode == 3);
        err_set = 1'b0;
        if (!rst_b) begin
            enter_flush();
            m_lost = 0;
            m_err  = 1'b0;
            return;
        end
        if (cal_busy || test_enable) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: enter_flush();
                1: begin
                    if (flush_left == 1) begin
                        m_mode   = synch_req ? 2 : 3;
                        hs_seen  = 0;
                        idle_cnt = 0;
                    end else begin
                        flush_left--;
                    end
                end
                2: begin
                    if (!synch_req && hs_seen >= SYNCH_MIN) enter_flush();
                    else if (handshake) hs_seen++;
                end
                default: begin
                    if (synch_req) begin
                        m_mode  = 2;
                        hs_seen = 0;
                    end else if (Orbit && orbit_flush_en) begin
                        enter_flush();
                    end else if (handshake) begin
                        idle_cnt = 0;
                    end else begin
                        idle_cnt++;
                        if (idle_cnt == HS_TIMEOUT) err_set = 1'b1;
                    end
                end
            endcase
        end
        if (clr_cnt) begin
            m_lost = 0;
            m_err  = 1'b0;
        end else begin
            if (was_run && losing_data && m_lost < CNT_MAX) m_lost++;
            if (err_set) m_err = 1'b1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        chk("state", int'(state), m_mode);
        chk("flush", int'(flush), int'(m_mode >= 2));
        chk("synch", int'(synch), int'(m_mode == 2));
        chk("ready", int'(ready), int'(m_mode == 3));
        chk("lost_cnt", int'(lost_cnt), m_lost);
        chk("link_err", int'(link_err), int'(m_err));
    endtask

    int flush_low;
    int cal_left;
    bit hs_dense;

    initial begin
        rst_b = 1'b0; cal_busy = 1'b0; test_enable = 1'b0; synch_req = 1'b0;
        orbit_flush_en = 1'b0; Orbit = 1'b0; handshake = 1'b0;
        losing_data = 1'b0; clr_cnt = 1'b0;
        m_mode = 1; flush_left = FLUSH_CYCLES; hs_seen = 0; idle_cnt = 0;
        m_lost = 0; m_err = 1'b0;

        repeat (3) tick();
        $display("reset held: state=%0d flush=%0b", state, flush);
        chk("reset_state", int'(state), 1);
        chk("reset_flush", int'(flush), 0);

        // Start-up: flush stays low exactly FLUSH_CYCLES cycles.
        rst_b = 1'b1;
        flush_low = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!flush) flush_low++;
        end
        $display("startup: flush low %0d cycles, state=%0d", flush_low, state);
        chk("startup_flush_len", flush_low, FLUSH_CYCLES - 1);
        chk("startup_run", int'(state), 3);

        // Synch request for 5 cycles, handshake every 4th cycle.
        synch_req = 1'b1;
        for (int i = 0; i < 110; i++) begin
            if (i == 5) synch_req = 1'b0;
            handshake = ((i % 4) == 3);
            tick();
        end
        handshake = 1'b1;
        $display("synch sequence done: state=%0d", state);
        chk("synch_back_to_run", int'(state), 3);

        // Calibration hold of 20 cycles.
        cal_busy = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        cal_busy = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        $display("calibration hold done: state=%0d", state);
        chk("cal_back_to_run", int'(state), 3);

        // Orbit and synch_req together: synch wins.
        orbit_flush_en = 1'b1; Orbit = 1'b1; synch_req = 1'b1;
        tick();
        Orbit = 1'b0; synch_req = 1'b0;
        $display("orbit+synch_req: state=%0d", state);
        chk("orbit_vs_synch", int'(state), 2);
        for (int i = 0; i < 30; i++) tick();
        Orbit = 1'b1;
        tick();
        Orbit = 1'b0;
        $display("orbit flush: state=%0d", state);
        chk("orbit_flush", int'(state), 1);
        for (int i = 0; i < 9; i++) tick();
        orbit_flush_en = 1'b0;

        // Handshake watchdog.
        handshake = 1'b0;
        for (int i = 0; i < HS_TIMEOUT + 4; i++) tick();
        $display("watchdog: link_err=%0b state=%0d", link_err, state);
        chk("wd_link_err", int'(link_err), 1);
        chk("wd_state", int'(state), 3);
        clr_cnt = 1'b1; handshake = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("wd_clear", int'(link_err), 0);

        // Lost-data saturation and clear-wins.
        losing_data = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        $display("losing_data 300 cycles: lost_cnt=%0d", lost_cnt);
        chk("lost_saturated", int'(lost_cnt), CNT_MAX);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0; losing_data = 1'b0;
        chk("lost_clear_wins", int'(lost_cnt), 0);

        // Random phase.
        cal_left = 0;
        hs_dense = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            rst_b = ($urandom_range(0, 599) != 0);
            if (cal_left == 0 && $urandom_range(0, 299) == 0) cal_left = $urandom_range(1, 30);
            cal_busy = (cal_left > 0);
            if (cal_left > 0) cal_left--;
            test_enable = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 79) == 0) synch_req = ~synch_req;
            if ($urandom_range(0, 199) == 0) orbit_flush_en = ~orbit_flush_en;
            Orbit = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) hs_dense = ~hs_dense;
            handshake = hs_dense && ($urandom_range(0, 2) == 0);
            losing_data = ($urandom_range(0, 7) == 0);
            clr_cnt = ($urandom_range(0, 149) == 0);
            tick();
        end
        $display("random phase done: state=%0d lost_cnt=%0d link_err=%0b", state, lost_cnt, link_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ldtu_link_ctrl.md
Name: ldtu_link_ctrl

Overview:
Sequencer for the LiTE-DTU output datapath.
- Drives the run-enable `flush` that releases the Encoder/Control Unit reset (their reset = rst_b & flush, so flush=0 holds them in reset).
- Drives `synch`, which makes the output FIFO send the synch pattern.
- Handles start-up, calibration/test hold, link synchronisation requests, optional per-orbit flush, and link health monitoring (losing_data count, handshake watchdog).

Parameters:
FLUSH_CYCLES, 8, cycles flush is held low on each entry to FLUSH
SYNCH_MIN, 16, minimum handshakes counted in SYNCH before exit is allowed
HS_TIMEOUT, 64, max CLK cycles without handshake in RUN before link_err
CNT_W, 8, width of lost_cnt
TMR_W, 8, width of internal timer; must hold max(FLUSH_CYCLES, SYNCH_MIN, HS_TIMEOUT)

Ports:
CLK  in  1  160 MHz system clock
rst_b  in  1  synchronous, active-low reset
cal_busy  in  1  CALIBRATION_BUSY_1 | CALIBRATION_BUSY_10
test_enable  in  1  ATU test mode
synch_req  in  1  level request from config: send synch pattern
orbit_flush_en  in  1  config: flush on every Orbit pulse
Orbit  in  1  one-cycle orbit marker
handshake  in  1  serializer read strobe, one per 32-bit word
losing_data  in  1  from Control Unit
clr_cnt  in  1  one-cycle clear of lost_cnt and link_err
flush  out  1  0 = hold Encoder/CU in reset, 1 = run
synch  out  1  1 = output FIFO emits synch_pattern
ready  out  1  1 only in RUN
state  out  2  HOLD=0, FLUSH=1, SYNCH=2, RUN=3
lost_cnt  out  CNT_W  saturating count of losing_data cycles in RUN
link_err  out  1  sticky handshake-timeout flag

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-low (CLK, rst_b). All outputs are registered.
- Reset values: state=FLUSH, timer=FLUSH_CYCLES-1, flush=0, synch=0, ready=0, lost_cnt=0, link_err=0.
- Transition priority, highest first: rst_b=0 > (cal_busy|test_enable) > state-local conditions.
- Any state, when cal_busy|test_enable=1: next state HOLD.
- HOLD: flush=0, synch=0. When cal_busy|test_enable=0, go to FLUSH and load timer=FLUSH_CYCLES-1.
- FLUSH: flush=0, synch=0, timer decrements each cycle. When timer==0:
  - synch_req=1 → SYNCH, timer cleared;
  - otherwise → RUN, timer cleared.
  - Net: flush is low for exactly FLUSH_CYCLES cycles.
- SYNCH: flush=1, synch=1.
  - Timer counts handshakes, saturating at SYNCH_MIN.
  - Exit to FLUSH only when synch_req=0 and timer==SYNCH_MIN. The flush realigns the encoder before data resumes.
  - If synch_req drops before SYNCH_MIN handshakes, stay in SYNCH until the count is reached.
- RUN: flush=1, synch=0, ready=1.
  - synch_req=1 → SYNCH, timer cleared. This wins over an Orbit in the same cycle.
  - Orbit=1 and orbit_flush_en=1 → FLUSH, load timer.
  - Otherwise the timer is the watchdog:
    - cleared on handshake, else increments, saturating;
    - reaching HS_TIMEOUT sets link_err (sticky) and the state stays RUN.
- Watchdog is inactive outside RUN. The timer is reused per state and reloaded on every state entry.
- lost_cnt: +1 on each cycle with losing_data=1 while state=RUN; saturates at 2^CNT_W-1. Not cleared by state changes.
- clr_cnt: zeroes lost_cnt and link_err. If clr_cnt coincides with an increment or timeout, the clear wins.
- Outputs change one cycle after the causing input is sampled. flush/synch/ready are decoded from the registered state only (glitch-free).

Decomposition:
- Shared package `ldtu_ctrl_pkg`: state encoding constants (HOLD/FLUSH/SYNCH/RUN) and default parameter values, reused by the top level and the testbench.
- One natural sub-module, `ldtu_link_monitor`: lost_cnt saturating counter, handshake watchdog, and clr_cnt logic.
- The FSM and timer stay in `ldtu_link_ctrl`.

Test Plan:
- Reset release, synch_req=0 → flush=0 for exactly 8 cycles, then state=3, flush=1, ready=1.
- RUN, synch_req=1 for 5 cycles with handshake every 4th cycle → synch=1 until 16 handshakes counted (~64 cycles), then 8-cycle flush, then RUN.
- RUN, cal_busy pulse of 20 cycles → state=0 next cycle, flush=0 throughout; after falling edge, 8-cycle FLUSH, then RUN.
- RUN, orbit_flush_en=1, Orbit and synch_req asserted in the same cycle → SYNCH entered, not FLUSH. Repeat with synch_req=0 → FLUSH of 8 cycles.
- RUN, no handshake for 64 cycles → link_err=1 and state stays 3. clr_cnt → link_err=0 next cycle.
- RUN, losing_data held 300 cycles → lost_cnt=255 (saturated). clr_cnt together with losing_data → lost_cnt=0.
